// File: rtl/jump_redirect_if.sv
// Handshake bundle between pre-decode, EXU/CSR resolution and the IFU PC register.
// Master drives instructions and resolutions; slave is the redirect controller.
interface jump_redirect_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [11:0]     in_class;
    logic            in_not_jump;
    logic            res_valid;
    logic            res_ready;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            fetch_hold;
    logic [31:0]     stall_cnt;

    modport master (
        output in_valid, in_pc, in_inst, in_class, in_not_jump,
        output res_valid, res_taken, res_target,
        input  in_ready, res_ready, redir_valid, redir_pc,
        input  fetch_hold, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_class, in_not_jump,
        input  res_valid, res_taken, res_target,
        output in_ready, res_ready, redir_valid, redir_pc,
        output fetch_hold, stall_cnt
    );
endinterface

// File: rtl/jump_redirect.sv
// Jump-class consumer: holds fetch, waits for resolution, pulses a PC redirect.
// STATIC_PRED_EN: predict backward branches taken with an early redirect.
module jump_redirect #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input logic            clk,
    input logic            rst,
    jump_redirect_if.slave bus
);
`ifdef STATIC_PRED_EN
    typedef enum logic [2:0] {
        IDLE, JAL_REDIR, WAIT_RES, REDIR, PRED
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, JAL_REDIR, WAIT_RES, REDIR
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [XLEN-1:0] tgt;
    logic            br_q, br_d;
    logic            pred_q, pred_d;
    logic [31:0]     stall_q;

    logic            cls_onehot;
    logic            is_jal, is_br, is_res;
    logic [XLEN-1:0] jimm;
    logic [XLEN-1:0] pc_plus4;
    logic            unused_inst;

    assign cls_onehot = (bus.in_class != 12'd0) &&
                        ((bus.in_class & (bus.in_class - 12'd1)) == 12'd0);
    assign is_jal = bus.in_class[3];
    assign is_br  = |bus.in_class[10:5];
    assign is_res = bus.in_class[4] | bus.in_class[2] | bus.in_class[1];

    assign jimm = {{(XLEN-20){bus.in_inst[31]}}, bus.in_inst[19:12],
                   bus.in_inst[20], bus.in_inst[30:21], 1'b0};
    assign pc_plus4 = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign unused_inst = &{1'b0, bus.in_inst[11:0]};

`ifdef STATIC_PRED_EN
    logic [XLEN-1:0] bimm;
    assign bimm = {{(XLEN-12){bus.in_inst[31]}}, bus.in_inst[7],
                   bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            redir_pc_q <= RESET_PC;
            br_q       <= 1'b0;
            pred_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            br_q       <= br_d;
            pred_q     <= pred_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        br_d    = br_q;
        pred_d  = pred_q;
        tgt     = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.in_not_jump && cls_onehot) begin
                    pc_d   = bus.in_pc;
                    br_d   = is_br;
                    pred_d = 1'b0;
                    if (is_jal) begin
                        tgt     = bus.in_pc + jimm;
                        state_d = JAL_REDIR;
                    end else if (is_br || is_res) begin
                        state_d = WAIT_RES;
`ifdef STATIC_PRED_EN
                        if (is_br && bus.in_inst[31]) begin
                            tgt     = bus.in_pc + bimm;
                            pred_d  = 1'b1;
                            state_d = PRED;
                        end
`endif
                    end
                end
            end
            WAIT_RES: begin
                if (bus.res_valid) begin
                    state_d = REDIR;
                    if (!br_q) begin
                        tgt = bus.res_target;
                    end else if (bus.res_taken) begin
                        // a correctly predicted branch already redirected fetch
                        if (pred_q) state_d = IDLE;
                        else        tgt = bus.res_target;
                    end else begin
                        tgt = pc_plus4;
                    end
                end
            end
`ifdef STATIC_PRED_EN
            PRED:      state_d = WAIT_RES;
`endif
            JAL_REDIR: state_d = IDLE;
            REDIR:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        redir_pc_d = {tgt[XLEN-1:1], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (bus.fetch_hold && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.res_ready   = (state_q == WAIT_RES);
`ifdef STATIC_PRED_EN
    assign bus.redir_valid = (state_q == JAL_REDIR) || (state_q == REDIR) ||
                             (state_q == PRED);
`else
    assign bus.redir_valid = (state_q == JAL_REDIR) || (state_q == REDIR);
`endif
    assign bus.fetch_hold  = (state_q == JAL_REDIR) || (state_q == REDIR) ||
                             ((state_q == WAIT_RES) && !pred_q);
    assign bus.redir_pc    = redir_pc_q;
    assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_jump_redirect.sv
// Directed and randomized checks of jump_redirect against a
// transaction-level model of redirect targets and stall cycles.
module tb_jump_redirect;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_pc;
    int unsigned exp_stall;

    always #5 clk = ~clk;

    jump_redirect_if #(.XLEN(32)) bus ();

    jump_redirect #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] enc_j(int off);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(int off);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], 5'd0, 5'd0, 3'b001, o[4:1], o[11], 7'h63};
    endfunction

    task automatic check_idle(string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_redir_valid"}, {31'd0, bus.redir_valid}, 32'd0);
        check({tag, "_fetch_hold"}, {31'd0, bus.fetch_hold}, 32'd0);
        check({tag, "_res_ready"}, {31'd0, bus.res_ready}, 32'd0);
        check({tag, "_redir_pc"}, bus.redir_pc, exp_pc);
        check({tag, "_stall_cnt"}, bus.stall_cnt, exp_stall);
    endtask

    task automatic clear_inputs();
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_inst     = '0;
        bus.in_class    = '0;
        bus.in_not_jump = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;
        bus.res_target  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        exp_pc    = RESET_PC;
        exp_stall = 0;
        check_idle("reset");
    endtask

    // kind: 0 sequential, 1 jal, 2 conditional branch, 3 jalr/ecall/mret
    function automatic int kind_of(logic [11:0] cls, logic nj);
        int n = 0;
        int idx = 0;
        for (int i = 0; i < 12; i++)
            if (cls[i]) begin n++; idx = i; end
        if (nj || n != 1) return 0;
        if (idx == 3) return 1;
        if (idx >= 5 && idx <= 10) return 2;
        if (idx == 1 || idx == 2 || idx == 4) return 3;
        return 0;
    endfunction

    task automatic run_instr(string tag, logic [31:0] pc, logic [11:0] cls,
                             logic nj, int off, int delay, logic taken,
                             logic [31:0] target);
        int k;
        logic pred;
        logic [31:0] t;
        k = kind_of(cls, nj);
        pred = 1'b0;
`ifdef STATIC_PRED_EN
        pred = (k == 2) && (off < 0);
`endif
        check_idle({tag, "_pre"});
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_class    = cls;
        bus.in_not_jump = nj;
        bus.in_inst     = cls[3] ? enc_j(off) : (k == 2) ? enc_b(off) : $urandom;
        bus.res_valid   = 1'($urandom % 2);
        bus.res_target  = $urandom;
        bus.res_taken   = 1'($urandom % 2);
        tick();
        clear_inputs();
        if (k == 1) begin
            exp_pc = (pc + 32'(off)) & ~32'd1;
            exp_stall++;
            check({tag, "_jal_pulse"}, {31'd0, bus.redir_valid}, 32'd1);
            check({tag, "_jal_hold"}, {31'd0, bus.fetch_hold}, 32'd1);
            check({tag, "_jal_ready"}, {31'd0, bus.in_ready}, 32'd0);
            check({tag, "_jal_pc"}, bus.redir_pc, exp_pc);
            tick();
        end else if (k >= 2) begin
            if (pred) begin
                exp_pc = (pc + 32'(off)) & ~32'd1;
                check({tag, "_pred_pulse"}, {31'd0, bus.redir_valid}, 32'd1);
                check({tag, "_pred_hold"}, {31'd0, bus.fetch_hold}, 32'd0);
                check({tag, "_pred_pc"}, bus.redir_pc, exp_pc);
                tick();
            end
            for (int i = 0; i <= delay; i++) begin
                if (!pred) exp_stall++;
                check({tag, "_wait_rdy"}, {31'd0, bus.res_ready}, 32'd1);
                check({tag, "_wait_hold"}, {31'd0, bus.fetch_hold}, {31'd0, !pred});
                check({tag, "_wait_pulse"}, {31'd0, bus.redir_valid}, 32'd0);
                check({tag, "_wait_inrdy"}, {31'd0, bus.in_ready}, 32'd0);
                if (i == delay) begin
                    bus.res_valid  = 1'b1;
                    bus.res_taken  = taken;
                    bus.res_target = target;
                end
                tick();
                clear_inputs();
            end
            if (k == 2) t = taken ? target : pc + 32'd4;
            else        t = target;
            t = t & ~32'd1;
            if (!(pred && taken)) begin
                exp_pc = t;
                exp_stall++;
                check({tag, "_redir_pulse"}, {31'd0, bus.redir_valid}, 32'd1);
                check({tag, "_redir_hold"}, {31'd0, bus.fetch_hold}, 32'd1);
                check({tag, "_redir_pc"}, bus.redir_pc, exp_pc);
                tick();
            end
        end
        check_idle({tag, "_post"});
    endtask

    initial begin
        logic [11:0] cls;
        logic        nj;
        int          r;
        int          off;
        clear_inputs();
        @(negedge clk);
        do_reset();

        run_instr("jal16", 32'h8000_0000, 12'h008, 1'b0, 16, 0, 1'b0, 32'h0);
        check("jal16_target", bus.redir_pc, 32'h8000_0010);

        do_reset();
        run_instr("beq_nt", 32'h8000_0100, 12'h020, 1'b0, 8, 2, 1'b0, 32'h1234_5678);
        check("beq_nt_target", bus.redir_pc, 32'h8000_0104);
        check("beq_nt_stall", bus.stall_cnt, 32'd4);

        run_instr("jalr", 32'h8000_0200, 12'h010, 1'b0, 0, 1, 1'b0, 32'h8000_0203);
        check("jalr_target", bus.redir_pc, 32'h8000_0202);
        run_instr("mret", 32'h8000_0300, 12'h004, 1'b0, 0, 0, 1'b1, 32'h8000_0040);
        check("mret_target", bus.redir_pc, 32'h8000_0040);
        run_instr("wrap", 32'hFFFF_FFFC, 12'h040, 1'b0, 8, 1, 1'b0, 32'h0);
        check("wrap_target", bus.redir_pc, 32'h0000_0000);
        run_instr("ebreak", 32'h8000_0400, 12'h001, 1'b1, 0, 0, 1'b0, 32'h0);

        // bne abandoned by reset while waiting for its resolution
        check_idle("mid_pre");
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h8000_0500;
        bus.in_class = 12'h040;
        bus.in_inst  = enc_b(12);
        tick();
        clear_inputs();
        check("mid_wait", {31'd0, bus.res_ready}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc    = RESET_PC;
        exp_stall = 0;
        check_idle("mid_rst");
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b1;
        bus.res_target = 32'h9000_0000;
        tick();
        clear_inputs();
        check_idle("mid_ignored");
        tick();
        check_idle("mid_after");

`ifdef STATIC_PRED_EN
        run_instr("pred_nt", 32'h8000_0020, 12'h040, 1'b0, -8, 1, 1'b0, 32'h0);
        check("pred_nt_target", bus.redir_pc, 32'h8000_0024);
        run_instr("pred_t", 32'h8000_0020, 12'h040, 1'b0, -8, 0, 1'b1, 32'h8000_0018);
        check("pred_t_target", bus.redir_pc, 32'h8000_0018);
`endif

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom % 16);
            if (r < 12)       cls = 12'd1 << r;
            else if (r == 12) cls = 12'd0;
            else              cls = (12'd1 << ($urandom % 12)) | (12'd1 << ($urandom % 12));
            nj = cls[11] | cls[0] | ($urandom % 8 == 0);
            if (cls[3]) off = int'($urandom_range(0, 32'hFFFFF)) * 2 - 32'h100000;
            else        off = int'($urandom_range(0, 4095)) * 2 - 4096;
            run_instr("rand", $urandom, cls, nj, off, int'($urandom % 4),
                      1'($urandom % 2), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
